dtpu_job_launcher: RTL and testbench

Host-side sequencer for the DTPU start/ready/done control handshake: the initiator that drives `cs_start` into the accelerator control unit and consumes its `cs_ready`/`cs_idle`/`cs_done` responses. It accepts a batch request (N jobs) from the PS register bank and launches the jobs back-to-back. It gates `glb_enable`, supervises each job with a watchdog, and reports progress and error status.

---
 rtl/dtpu_job_launcher.sv | 179 +++++++++++++++++
 tb/tb_dtpu_job_launcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtpu_job_launcher.sv
// dtpu_job_launcher: host-side sequencer for the DTPU start/ready/done handshake.
// Accepts a batch of N jobs, launches them back-to-back against the control
// unit, supervises each start/run phase with a watchdog and reports progress.
module dtpu_job_launcher #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic             abort,
  output logic             glb_enable,
  output logic             cs_start,
  output logic             cs_continue,
  input  logic             cs_ready,
  input  logic             cs_idle,
  input  logic             cs_done,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic             done_pulse,
  output logic             err_timeout,
  output logic             err_protocol
);

  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_START,
    S_WAIT_DONE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   jobs_done_q, jobs_done_d;
  logic               req_ready_q, req_ready_d;
  logic               glb_enable_q, glb_enable_d;
  logic               cs_start_q, cs_start_d;
  logic               cs_continue_q, cs_continue_d;
  logic               busy_q, busy_d;
  logic               done_pulse_q, done_pulse_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_protocol_q, err_protocol_d;

  // State, batch bookkeeping and every output are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      target_q       <= '0;
      timer_q        <= '0;
      jobs_done_q    <= '0;
      req_ready_q    <= 1'b0;
      glb_enable_q   <= 1'b0;
      cs_start_q     <= 1'b0;
      cs_continue_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_pulse_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      timer_q        <= timer_d;
      jobs_done_q    <= jobs_done_d;
      req_ready_q    <= req_ready_d;
      glb_enable_q   <= glb_enable_d;
      cs_start_q     <= cs_start_d;
      cs_continue_q  <= cs_continue_d;
      busy_q         <= busy_d;
      done_pulse_q   <= done_pulse_d;
      err_timeout_q  <= err_timeout_d;
      err_protocol_q <= err_protocol_d;
    end
  end

  // Next-state, watchdog and event logic; level outputs follow the next state
  // so they are valid in the same cycle the state is entered.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    timer_d        = timer_q;
    jobs_done_d    = jobs_done_q;
    err_timeout_d  = err_timeout_q;
    err_protocol_d = err_protocol_q;
    cs_continue_d  = 1'b0;
    done_pulse_d   = 1'b0;

    if (abort) begin
      // Abort keeps progress and error flags for the host to inspect.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            jobs_done_d    = '0;
            err_timeout_d  = 1'b0;
            err_protocol_d = 1'b0;
            if (req_count != '0) begin
              target_d = req_count;
              state_d  = S_WAIT_IDLE;
            end else begin
              done_pulse_d = 1'b1;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (cs_idle) begin
            state_d = S_START;
            timer_d = '0;
          end
        end
        S_START: begin
          // A done before any ready is a responder protocol violation.
          if (cs_done) begin
            err_protocol_d = 1'b1;
            state_d        = S_ERROR;
          end else if (cs_ready) begin
            state_d = S_WAIT_DONE;
            timer_d = '0;
          end else if (timer_q == TMR_LIMIT) begin
            err_timeout_d = 1'b1;
            state_d       = S_ERROR;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          // Exit event checked before the limit so a done at the limit wins.
          if (cs_done) begin
            cs_continue_d = 1'b1;
            jobs_done_d   = (jobs_done_q == CNT_MAX) ? jobs_done_q
                                                     : jobs_done_q + CNT_W'(1);
            state_d       = (jobs_done_d == target_q) ? S_FINISH : S_WAIT_IDLE;
          end else if (timer_q == TMR_LIMIT) begin
            err_timeout_d = 1'b1;
            state_d       = S_ERROR;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_FINISH: begin
          done_pulse_d = 1'b1;
          state_d      = S_IDLE;
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    cs_start_d   = (state_d == S_START);
    glb_enable_d = (state_d == S_WAIT_IDLE) || (state_d == S_START) ||
                   (state_d == S_WAIT_DONE) || (state_d == S_FINISH);
  end

  assign req_ready    = req_ready_q;
  assign glb_enable   = glb_enable_q;
  assign cs_start     = cs_start_q;
  assign cs_continue  = cs_continue_q;
  assign busy         = busy_q;
  assign jobs_done    = jobs_done_q;
  assign done_pulse   = done_pulse_q;
  assign err_timeout  = err_timeout_q;
  assign err_protocol = err_protocol_q;

endmodule

// File: tb/tb_dtpu_job_launcher.sv
// tb_dtpu_job_launcher: scoreboard bench with a behavioural control-unit responder.
module tb_dtpu_job_launcher;

  localparam int CNT_W = 16;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic             abort;
  logic             glb_enable;
  logic             cs_start;
  logic             cs_continue;
  logic             cs_ready;
  logic             cs_idle;
  logic             cs_done;
  logic             busy;
  logic [CNT_W-1:0] jobs_done;
  logic             done_pulse;
  logic             err_timeout;
  logic             err_protocol;

  dtpu_job_launcher #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_count(req_count), .abort(abort), .glb_enable(glb_enable),
    .cs_start(cs_start), .cs_continue(cs_continue), .cs_ready(cs_ready),
    .cs_idle(cs_idle), .cs_done(cs_done), .busy(busy), .jobs_done(jobs_done),
    .done_pulse(done_pulse), .err_timeout(err_timeout), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: 2-cycle power-up, ready after 4 sampled starts, done done_lat
  // cycles after ready. mode 1 never finishes, mode 2 raises done during start.
  int mode     = 0;
  int done_lat = 10;
  int r_st, r_cnt, en_cnt;
  always @(posedge clk) begin
    if (!reset || !glb_enable) begin
      r_st <= 0; r_cnt <= 0; en_cnt <= 0;
      cs_ready <= 1'b0; cs_done <= 1'b0; cs_idle <= 1'b0;
    end else begin
      cs_ready <= 1'b0;
      cs_done  <= 1'b0;
      if (en_cnt < 2) en_cnt <= en_cnt + 1;
      cs_idle <= (r_st == 0) && (en_cnt >= 1);
      case (r_st)
        0: if (cs_start) begin
          if (mode == 2 && r_cnt == 1) begin
            cs_done <= 1'b1; r_cnt <= 0; r_st <= 2;
          end else if (r_cnt == 3) begin
            cs_ready <= 1'b1; r_cnt <= 0; r_st <= 1;
          end else begin
            r_cnt <= r_cnt + 1;
          end
        end
        1: if (mode != 1) begin
          if (r_cnt == done_lat - 1) begin
            cs_done <= 1'b1; r_cnt <= 0; r_st <= 2;
          end else begin
            r_cnt <= r_cnt + 1;
          end
        end
        2: if (cs_continue) r_st <= 0;
        default: r_st <= 0;
      endcase
    end
  end

  // Scoreboard of expected {kind, jobs_done}: kind 1 = cs_continue, 2 = done_pulse.
  logic [31:0] exp_q[$];

  task automatic sb_pop(input logic [7:0] kind);
    logic [31:0] code;
    code = {8'h00, kind, jobs_done};
    $display("[%0d] event kind=%0d jobs_done=%0d", cyc, kind, jobs_done);
    if (exp_q.size() == 0) chk("sb_unexpected", code, 32'h0);
    else chk("sb_event", code, exp_q.pop_front());
  endtask

  task automatic push_batch(input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back({8'h00, 8'h01, CNT_W'(i)});
    exp_q.push_back({8'h00, 8'h02, CNT_W'(n)});
  endtask

  // Monitor: counts events and records cycle stamps, on the falling edge.
  logic prev_start = 1'b0;
  logic prev_tmo   = 1'b0;
  int start_count = 0, start_fall_count = 0, cont_count = 0, done_count = 0;
  int start_rise_cyc = 0, start_fall_cyc = 0, last_start_len = 0;
  int tmo_cyc = 0, done_cyc = 0, last_csdone_cyc = 0;
  always @(negedge clk) begin
    if (cs_start && !prev_start) begin
      start_count    <= start_count + 1;
      start_rise_cyc <= cyc;
    end
    if (!cs_start && prev_start) begin
      start_fall_count <= start_fall_count + 1;
      start_fall_cyc   <= cyc;
      last_start_len   <= cyc - start_rise_cyc;
    end
    prev_start <= cs_start;
    if (cs_done) last_csdone_cyc <= cyc;
    if (err_timeout && !prev_tmo) tmo_cyc <= cyc;
    prev_tmo <= err_timeout;
    if (cs_continue) begin
      cont_count <= cont_count + 1;
      sb_pop(8'h01);
    end
    if (done_pulse) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
      sb_pop(8'h02);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic probe(input int which, input int target);
    case (which)
      0:       return done_pulse;
      1:       return err_timeout;
      2:       return err_protocol;
      3:       return cs_start;
      4:       return start_fall_count >= target;
      default: return cont_count >= target;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int which, input int target, input int budget);
    int n = 0;
    while (!probe(which, target) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(probe(which, target)), 32'd1);
  endtask

  task automatic send_req(input int n);
    req_valid = 1'b1;
    req_count = CNT_W'(n);
    tick();
    req_valid = 1'b0;
    req_count = '0;
  endtask

  function automatic logic [31:0] outs_vec();
    return {8'h00, req_ready, glb_enable, cs_start, cs_continue, busy,
            done_pulse, err_timeout, err_protocol, jobs_done};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int s0, c0, d0, f0;
    reset = 1'b0; req_valid = 1'b0; req_count = '0; abort = 1'b0;
    repeat (3) tick();
    chk("reset_outs", outs_vec(), 32'h0);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", req_ready, 1);

    // Single job
    mode = 0; done_lat = 10;
    push_batch(1);
    s0 = start_count;
    send_req(1);
    chk("single_glb_on", glb_enable, 1);
    chk("single_busy_on", busy, 1);
    wait_until("single_done", 0, 0, 300);
    chk("single_starts", start_count - s0, 1);
    chk("single_start_len", last_start_len, 5);
    chk("single_jobs", jobs_done, 1);
    chk("single_errs", {err_timeout, err_protocol}, 0);
    tick();
    chk("single_idle", busy, 0);

    // Batch of 3
    push_batch(3);
    s0 = start_count; c0 = cont_count;
    send_req(3);
    wait_until("batch_done", 0, 0, 600);
    chk("batch_starts", start_count - s0, 3);
    chk("batch_conts", cont_count - c0, 3);
    chk("batch_done_lat", done_cyc - last_csdone_cyc, 2);
    chk("batch_jobs", jobs_done, 3);
    tick();
    chk("batch_busy_low", busy, 0);

    // Zero-count request
    exp_q.push_back({8'h00, 8'h02, 16'h0000});
    s0 = start_count; d0 = done_count;
    send_req(0);
    chk("zero_pulse", done_pulse, 1);
    chk("zero_jobs", jobs_done, 0);
    tick();
    chk("zero_pulse_len", done_pulse, 0);
    repeat (10) tick();
    chk("zero_no_start", start_count - s0, 0);
    chk("zero_one_pulse", done_count - d0, 1);

    // Done arriving on the watchdog limit cycle wins
    done_lat = TO;
    push_batch(1);
    send_req(1);
    wait_until("limit_done", 0, 0, 300);
    chk("limit_no_tmo", err_timeout, 0);
    chk("limit_jobs", jobs_done, 1);
    tick();

    // Timeout with a responder that never finishes
    mode = 1;
    send_req(1);
    wait_until("tmo", 1, 0, 300);
    chk("tmo_latency", tmo_cyc - start_fall_cyc, TO);
    chk("tmo_glb_off", glb_enable, 0);
    chk("tmo_start_off", cs_start, 0);
    chk("tmo_busy", busy, 1);
    repeat (5) tick();
    chk("tmo_hold", {busy, req_ready}, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tmo_abort_ready", req_ready, 1);
    chk("tmo_flag_kept", err_timeout, 1);

    // Protocol error: done during start
    mode = 2;
    send_req(1);
    chk("tmo_cleared", err_timeout, 0);
    wait_until("prot", 2, 0, 100);
    chk("prot_start_low", cs_start, 0);
    chk("prot_glb_off", glb_enable, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mode = 0; done_lat = 10;
    push_batch(2);
    send_req(2);
    chk("prot_flags_clear", {err_timeout, err_protocol}, 0);
    wait_until("prot_batch_done", 0, 0, 600);
    chk("prot_batch_jobs", jobs_done, 2);
    tick();

    // Abort mid-run of job 2 of 4
    exp_q.push_back({8'h00, 8'h01, 16'h0001});
    f0 = start_fall_count; d0 = done_count;
    send_req(4);
    wait_until("abort_job2", 4, f0 + 2, 400);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy, glb_enable, cs_start, req_ready}, 4'b0001);
    chk("abort_jobs", jobs_done, 1);
    repeat (30) tick();
    chk("abort_no_done", done_count - d0, 0);

    // Abort together with a request in IDLE
    s0 = start_count;
    req_valid = 1'b1; req_count = 16'd3; abort = 1'b1;
    tick();
    req_valid = 1'b0; req_count = '0; abort = 1'b0;
    chk("abort_req_rejected", {busy, glb_enable}, 2'b00);
    repeat (8) tick();
    chk("abort_req_no_start", start_count - s0, 0);
    chk("abort_req_ready", req_ready, 1);

    // Reset during START
    send_req(1);
    wait_until("rst_start", 3, 0, 50);
    reset = 1'b0;
    tick();
    chk("rst_outs", outs_vec(), 32'h0);
    reset = 1'b1;
    tick();
    chk("rst_ready", req_ready, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
